multicycle_ctrl_fsm: RTL and testbench

//  Main control state machine for the multi-cycle build of the MIPS-subset CPU.

---
 rtl/multicycle_ctrl_fsm.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle MIPS-subset main control FSM; sequences fetch/decode/execute over a shared memory port.
// Ports: clk_i/rst_i (sync active-high), opcode_i from IR, zero_i from ALU, mem_ready_i memory handshake;
// datapath strobes/selects (pc_write_o .. pc_source_o), state_o debug, illegal_o in TRAP, instr_count_o retired count.
module multicycle_ctrl_fsm #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] OP_R    = 6'h00,
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2B,
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_BNE  = 6'h05,
  parameter logic [5:0] OP_J    = 6'h02,
  parameter logic [5:0] OP_ADDI = 6'h08
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             branch_type_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_count_o
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    TRAP   = 4'd15
  } state_t;
  state_t state;
  logic   retire;
  assign state_o = state;
  assign retire = state == MEMWB || state == RWB || state == ADDIWB || state == BRANCH ||
                  state == JUMP || (state == MEMWR && mem_ready_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= FETCH;
      instr_count_o <= '0;
    end else begin
      if (retire) instr_count_o <= instr_count_o + 1'b1;
      case (state)
        FETCH:  if (mem_ready_i) state <= DECODE;
        DECODE: begin
          if (opcode_i == OP_LW || opcode_i == OP_SW) state <= MEMADR;
          else if (opcode_i == OP_R) state <= EXEC;
          else if (opcode_i == OP_BEQ || opcode_i == OP_BNE) state <= BRANCH;
          else if (opcode_i == OP_J) state <= JUMP;
          else if (opcode_i == OP_ADDI) state <= ADDIEX;
          else state <= TRAP;
        end
        MEMADR: if (opcode_i == OP_LW) state <= MEMRD; else state <= MEMWR;
        MEMRD:  if (mem_ready_i) state <= MEMWB;
        MEMWR:  if (mem_ready_i) state <= FETCH;
        EXEC:   state <= RWB;
        ADDIEX: state <= ADDIWB;
        TRAP:   state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end
  // Outputs decode straight from state so FETCH can gate its PC/IR loads with mem_ready_i;
  // the reset cycle forces everything low so an aborted instruction writes nothing.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_type_o   = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 3'b000;
    pc_source_o     = 2'b00;
    illegal_o       = 1'b0;
    if (!rst_i) begin
      case (state)
        FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        DECODE: alu_src_b_o = 2'b11;
        MEMADR, ADDIEX: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
        end
        MEMRD: begin
          iord_o     = 1'b1;
          mem_read_o = 1'b1;
        end
        MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        MEMWR: begin
          iord_o      = 1'b1;
          mem_write_o = 1'b1;
        end
        EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'b010;
        end
        RWB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        ADDIWB: reg_write_o = 1'b1;
        BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = 3'b001;
          pc_write_cond_o = 1'b1;
          pc_source_o     = 2'b01;
          branch_type_o   = opcode_i == OP_BNE;
        end
        JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = 2'b10;
        end
        TRAP: illegal_o = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized instruction-plan checker for multicycle_ctrl_fsm with a 4-bit retire counter.
module tb_multicycle_ctrl_fsm;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_J = 6'h02, OP_ADDI = 6'h08;
  logic clk_i = 1'b0, rst_i, zero_i, mem_ready_i;
  logic [5:0] opcode_i;
  logic pc_write_o, pc_write_cond_o, branch_type_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o, instr_count_o, cnt_m;
  logic [18:0] obs;
  int n = 0, errs = 0;
  typedef struct { logic [3:0] st; logic rdy; logic [18:0] ctl; bit ret; } cyc_t;
  cyc_t q[$];
  multicycle_ctrl_fsm #(.CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_type_o(branch_type_o),
    .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .state_o(state_o), .illegal_o(illegal_o), .instr_count_o(instr_count_o)
  );
  assign obs = {pc_write_o, pc_write_cond_o, branch_type_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
                mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, illegal_o};
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [18:0] pk(input bit pcw, pcc, bt, iord, mr, mw, irw, m2r, rd, rw, sa,
                                     input logic [1:0] sb, input logic [2:0] ao, input logic [1:0] ps, input bit ill);
    return {pcw, pcc, bt, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
  endfunction
  function automatic void add(input logic [3:0] st, input logic rdy, input logic [18:0] ctl, input bit ret);
    cyc_t e;
    e.st = st; e.rdy = rdy; e.ctl = ctl; e.ret = ret;
    q.push_back(e);
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic bit legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
  endfunction
  task automatic do_reset(input logic [3:0] st);
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_ready_i = rb();
    #1;
    chk("rst_state", state_o, st);
    chk("rst_ctl", obs, 19'd0);
    chk("rst_count", instr_count_o, cnt_m);
    cnt_m = 4'd0;
  endtask
  // Builds the expected cycle-by-cycle plan of one instruction from its class and wait counts,
  // then plays it, optionally cutting it short with a reset at plan index rst_at.
  task automatic run(input logic [5:0] op, input int fw, input int mw, input int rst_at);
    bit bad = 0;
    q.delete();
    for (int i = 0; i < fw; i++) add(0, 0, pk(0,0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0), 0);
    add(0, 1, pk(1,0,0,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00,0), 0);
    add(1, rb(), pk(0,0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0), 0);
    case (op)
      OP_R: begin
        add(6, rb(), pk(0,0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0), 0);
        add(7, rb(), pk(0,0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0), 1);
      end
      OP_LW: begin
        add(2, rb(), pk(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0), 0);
        for (int i = 0; i < mw; i++) add(3, 0, pk(0,0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0), 0);
        add(3, 1, pk(0,0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0), 0);
        add(4, rb(), pk(0,0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0), 1);
      end
      OP_SW: begin
        add(2, rb(), pk(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0), 0);
        for (int i = 0; i < mw; i++) add(5, 0, pk(0,0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0), 0);
        add(5, 1, pk(0,0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0), 1);
      end
      OP_BEQ, OP_BNE: add(8, rb(), pk(0,1,op == OP_BNE,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0), 1);
      OP_J: add(9, rb(), pk(1,0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0), 1);
      OP_ADDI: begin
        add(10, rb(), pk(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0), 0);
        add(11, rb(), pk(0,0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0), 1);
      end
      default: begin
        bad = 1;
        for (int i = 0; i < 20; i++) add(15, rb(), pk(0,0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1), 0);
      end
    endcase
    if (bad && (rst_at < 0 || rst_at > q.size())) rst_at = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (i == rst_at) begin
        do_reset(q[i].st);
        return;
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      mem_ready_i = q[i].rdy;
      zero_i = rb();
      opcode_i = op;
      #1;
      chk("state", state_o, q[i].st);
      chk("ctl", obs, q[i].ctl);
      chk("count", instr_count_o, cnt_m);
      if (q[i].ret) cnt_m = cnt_m + 4'd1;
    end
    if (rst_at == q.size()) do_reset(bad ? 4'd15 : 4'd0);
  endtask
  initial begin
    logic [5:0] ops [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
    logic [5:0] o;
    int k, fw, ra;
    rst_i = 1'b1; opcode_i = 6'h00; mem_ready_i = 1'b0; zero_i = 1'b0;
    repeat (2) @(negedge clk_i);
    cnt_m = 4'd0;
    run(OP_R, 0, 0, -1);
    run(OP_LW, 2, 3, -1);
    run(OP_BNE, 0, 0, -1);
    run(OP_BEQ, 1, 0, -1);
    run(OP_SW, 1, 2, -1);
    run(OP_ADDI, 0, 0, -1);
    run(OP_LW, 0, 3, 4);
    run(6'h3F, 0, 0, -1);
    for (int i = 0; i < 16; i++) run(OP_J, 0, 0, -1);
    run(OP_J, 0, 0, -1);
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 13);
      if (k < 12) o = ops[k % 7];
      else do o = 6'($urandom); while (legal(o));
      fw = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
      ra = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 6) : -1;
      run(o, fw, $urandom_range(0, 1) ? 0 : $urandom_range(1, 4), ra);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
